// File: rtl/wb_merge.sv
// Register-file writeback merge: two pipe results plus a 2-entry buffered MDU result stream onto two write ports.
// Optional stall counter enabled by defining WB_MERGE_PERF_EN.
module wb_merge #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  pa_valid,
   input  logic [ADDR_WIDTH-1:0] pa_rd,
   input  logic [DATA_WIDTH-1:0] pa_data,
   input  logic                  pb_valid,
   input  logic [ADDR_WIDTH-1:0] pb_rd,
   input  logic [DATA_WIDTH-1:0] pb_data,
   input  logic                  mdu_valid,
   input  logic [ADDR_WIDTH-1:0] mdu_rd,
   input  logic [DATA_WIDTH-1:0] mdu_data,
   output logic                  mdu_ready,
   output logic                  we_a,
   output logic [ADDR_WIDTH-1:0] waddr_a,
   output logic [DATA_WIDTH-1:0] wdata_a,
   output logic                  we_b,
   output logic [ADDR_WIDTH-1:0] waddr_b,
   output logic [DATA_WIDTH-1:0] wdata_b,
   output logic [31:0]           stall_cnt
);

   logic [ADDR_WIDTH-1:0] fifo_rd   [2];
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [1:0]            fifo_live;
   logic                  rptr, wptr;
   logic [1:0]            count;

   logic [1:0]            live_eff;
   logic                  head_present, sec_present, head_live, sec_live;
   logic                  head_pop, head_to_a, head_to_b, sec_pop, sec_to_b, head_shadowed;
   logic [1:0]            pops, drain_count;
   logic                  push;
   logic                  we_a_n, we_b_n;
   logic [ADDR_WIDTH-1:0] waddr_a_n, waddr_b_n;
   logic [DATA_WIDTH-1:0] wdata_a_n, wdata_b_n;

   // A pipe write in the same cycle is younger than anything buffered, so it kills matching entries.
   always_comb begin
      live_eff = '0;
      for (int i = 0; i < 2; i++) begin
         live_eff[i] = fifo_live[i]
                       && !(pa_valid && pa_rd == fifo_rd[i])
                       && !(pb_valid && pb_rd == fifo_rd[i]);
      end
      head_present = (count != 2'd0);
      sec_present  = (count == 2'd2);
      head_live    = live_eff[rptr];
      sec_live     = live_eff[~rptr];

      head_pop  = 1'b0;
      head_to_a = 1'b0;
      head_to_b = 1'b0;
      sec_pop   = 1'b0;
      sec_to_b  = 1'b0;
      if (head_present) begin
         if (!head_live) begin
            head_pop = 1'b1;
         end else if (!pa_valid) begin
            head_to_a = 1'b1;
            head_pop  = 1'b1;
         end else if (!pb_valid) begin
            head_to_b = 1'b1;
            head_pop  = 1'b1;
         end
      end
      if (sec_present && head_pop) begin
         if (!sec_live) begin
            sec_pop = 1'b1;
         end else if (head_to_a && !pb_valid) begin
            sec_to_b = 1'b1;
            sec_pop  = 1'b1;
         end
      end

      pops          = {1'b0, head_pop} + {1'b0, sec_pop};
      drain_count   = count - pops;
      mdu_ready     = (drain_count < 2'd2);
      push          = mdu_valid && mdu_ready && (mdu_rd != '0);
      head_shadowed = head_to_a && sec_to_b && (fifo_rd[rptr] == fifo_rd[~rptr]);

      we_a_n    = 1'b0;
      waddr_a_n = '0;
      wdata_a_n = '0;
      if (pa_valid) begin
         we_a_n    = (pa_rd != '0) && !(pb_valid && pb_rd == pa_rd);
         waddr_a_n = pa_rd;
         wdata_a_n = pa_data;
      end else if (head_to_a) begin
         we_a_n    = !head_shadowed;
         waddr_a_n = fifo_rd[rptr];
         wdata_a_n = fifo_data[rptr];
      end

      we_b_n    = 1'b0;
      waddr_b_n = '0;
      wdata_b_n = '0;
      if (pb_valid) begin
         we_b_n    = (pb_rd != '0);
         waddr_b_n = pb_rd;
         wdata_b_n = pb_data;
      end else if (head_to_b) begin
         we_b_n    = 1'b1;
         waddr_b_n = fifo_rd[rptr];
         wdata_b_n = fifo_data[rptr];
      end else if (sec_to_b) begin
         we_b_n    = 1'b1;
         waddr_b_n = fifo_rd[~rptr];
         wdata_b_n = fifo_data[~rptr];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rptr      <= 1'b0;
         wptr      <= 1'b0;
         count     <= 2'd0;
         fifo_live <= 2'b00;
      end else begin
         rptr      <= rptr ^ (pops == 2'd1);
         wptr      <= wptr ^ push;
         count     <= drain_count + {1'b0, push};
         fifo_live <= live_eff;
         if (push) begin
            fifo_live[wptr] <= 1'b1;
         end
      end
   end

   // Payload storage needs no reset; validity lives in fifo_live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wptr]   <= mdu_rd;
         fifo_data[wptr] <= mdu_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_a    <= 1'b0;
         waddr_a <= '0;
         wdata_a <= '0;
         we_b    <= 1'b0;
         waddr_b <= '0;
         wdata_b <= '0;
      end else begin
         we_a    <= we_a_n;
         waddr_a <= waddr_a_n;
         wdata_a <= wdata_a_n;
         we_b    <= we_b_n;
         waddr_b <= waddr_b_n;
         wdata_b <= wdata_b_n;
      end
   end

`ifdef WB_MERGE_PERF_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (head_present && pops == 2'd0 && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Scoreboard bench for wb_merge: each driven cycle pushes the expected port writes, checked one cycle later.
module tb_wb_merge;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pa_valid, pb_valid, mdu_valid;
   logic [4:0]  pa_rd, pb_rd, mdu_rd;
   logic [31:0] pa_data, pb_data, mdu_data;
   logic        mdu_ready;
   logic        we_a, we_b;
   logic [4:0]  waddr_a, waddr_b;
   logic [31:0] wdata_a, wdata_b;
   logic [31:0] stall_cnt;

   typedef struct {
      logic        we_a;
      logic [4:0]  waddr_a;
      logic [31:0] wdata_a;
      logic        we_b;
      logic [4:0]  waddr_b;
      logic [31:0] wdata_b;
   } exp_t;

   exp_t expQ[$];
   int   testCount = 0;
   int   failCount = 0;

`ifdef WB_MERGE_PERF_EN
   localparam logic [31:0] STALL_EXP = 32'd2;
`else
   localparam logic [31:0] STALL_EXP = 32'd0;
`endif

   wb_merge dut (
      .clk(clk), .rstn(rstn),
      .pa_valid(pa_valid), .pa_rd(pa_rd), .pa_data(pa_data),
      .pb_valid(pb_valid), .pb_rd(pb_rd), .pb_data(pb_data),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .mdu_ready(mdu_ready),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md);
      pa_valid = av; pa_rd = ar; pa_data = ad;
      pb_valid = bv; pb_rd = br; pb_data = bd;
      mdu_valid = mv; mdu_rd = mr; mdu_data = md;
   endtask

   task automatic expectWrite(input logic ea, input logic [4:0] aa, input logic [31:0] da,
                              input logic eb, input logic [4:0] ab, input logic [31:0] db);
      exp_t e;
      e.we_a = ea; e.waddr_a = aa; e.wdata_a = da;
      e.we_b = eb; e.waddr_b = ab; e.wdata_b = db;
      expQ.push_back(e);
   endtask

   task automatic expectIdle();
      expectWrite(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Advance one edge, then compare the registered ports against the oldest expectation.
   task automatic stepCycle(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = expQ.pop_front();
         checkOutput({tag, "_we_a"}, {31'd0, we_a}, {31'd0, e.we_a});
         checkOutput({tag, "_we_b"}, {31'd0, we_b}, {31'd0, e.we_b});
         if (e.we_a) begin
            checkOutput({tag, "_waddr_a"}, {27'd0, waddr_a}, {27'd0, e.waddr_a});
            checkOutput({tag, "_wdata_a"}, wdata_a, e.wdata_a);
         end
         if (e.we_b) begin
            checkOutput({tag, "_waddr_b"}, {27'd0, waddr_b}, {27'd0, e.waddr_b});
            checkOutput({tag, "_wdata_b"}, wdata_b, e.wdata_b);
         end
      end
      @(negedge clk);
   endtask

   task automatic checkReady(input string tag, input logic expected);
      #1;
      checkOutput(tag, {31'd0, mdu_ready}, {31'd0, expected});
   endtask

   initial begin
      rstn = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      checkOutput("rst_we_a", {31'd0, we_a}, 32'd0);
      checkOutput("rst_we_b", {31'd0, we_b}, 32'd0);
      checkOutput("rst_ready", {31'd0, mdu_ready}, 32'd1);
      checkOutput("rst_stall", stall_cnt, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      expectIdle();
      stepCycle("idle");

      // Two independent pipe writes
      applyStimulus(1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0);
      expectWrite(1, 5, 32'h11, 1, 6, 32'h22);
      stepCycle("dual");

      // Same rd on both pipes: B wins alone
      applyStimulus(1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 0);
      expectWrite(0, 0, 0, 1, 7, 32'hBB);
      stepCycle("samerd");

      // FIFO fill while pipes busy, then dual drain
      applyStimulus(1, 10, 32'h100, 1, 11, 32'h101, 1, 3, 32'h33);
      checkReady("fill_rdy1", 1'b1);
      expectWrite(1, 10, 32'h100, 1, 11, 32'h101);
      stepCycle("fill1");
      applyStimulus(1, 12, 32'h102, 1, 13, 32'h103, 1, 4, 32'h44);
      checkReady("fill_rdy2", 1'b1);
      expectWrite(1, 12, 32'h102, 1, 13, 32'h103);
      stepCycle("fill2");
      applyStimulus(1, 14, 32'h104, 1, 15, 32'h105, 1, 8, 32'h88);
      checkReady("fill_rdy3", 1'b0);
      expectWrite(1, 14, 32'h104, 1, 15, 32'h105);
      stepCycle("fill3");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 8, 32'h88);
      checkReady("drain_rdy", 1'b1);
      expectWrite(1, 3, 32'h33, 1, 4, 32'h44);
      stepCycle("drain2");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expectWrite(1, 8, 32'h88, 0, 0, 0);
      stepCycle("drain1");
      checkOutput("stall_fill", stall_cnt, STALL_EXP);

      // Buffered entry overwritten by younger pipe A write
      applyStimulus(1, 12, 32'h200, 1, 13, 32'h201, 1, 9, 32'h99);
      expectWrite(1, 12, 32'h200, 1, 13, 32'h201);
      stepCycle("kill_push");
      applyStimulus(1, 9, 32'h01, 1, 14, 32'h202, 0, 0, 0);
      expectWrite(1, 9, 32'h01, 1, 14, 32'h202);
      stepCycle("kill_pipe");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expectIdle();
      stepCycle("kill_none1");
      expectIdle();
      stepCycle("kill_none2");
      checkOutput("stall_kill", stall_cnt, STALL_EXP);

      // rd 0 suppressed everywhere and never buffered
      applyStimulus(1, 0, 32'hFF, 0, 0, 0, 1, 0, 32'h77);
      checkReady("zero_rdy", 1'b1);
      expectIdle();
      stepCycle("zero");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expectIdle();
      stepCycle("zero_empty");

      // Two buffered entries with equal rd drain together: only the younger, on B
      applyStimulus(1, 21, 32'h300, 1, 22, 32'h301, 1, 20, 32'hA0);
      expectWrite(1, 21, 32'h300, 1, 22, 32'h301);
      stepCycle("dup1");
      applyStimulus(1, 23, 32'h302, 1, 24, 32'h303, 1, 20, 32'hB0);
      expectWrite(1, 23, 32'h302, 1, 24, 32'h303);
      stepCycle("dup2");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkReady("dup_rdy", 1'b1);
      expectWrite(0, 0, 0, 1, 20, 32'hB0);
      stepCycle("dup_drain");

      // Head drains to port B when only pipe A is busy
      applyStimulus(1, 1, 32'h400, 1, 2, 32'h401, 1, 25, 32'h55);
      expectWrite(1, 1, 32'h400, 1, 2, 32'h401);
      stepCycle("toB_push");
      applyStimulus(1, 26, 32'h66, 0, 0, 0, 0, 0, 0);
      expectWrite(1, 26, 32'h66, 1, 25, 32'h55);
      stepCycle("toB_drain");

      // Reset mid-operation with two buffered entries
      applyStimulus(1, 1, 32'h10, 1, 2, 32'h20, 1, 27, 32'h77);
      expectWrite(1, 1, 32'h10, 1, 2, 32'h20);
      stepCycle("rst_fill1");
      applyStimulus(1, 3, 32'h30, 1, 4, 32'h40, 1, 28, 32'h78);
      expectWrite(1, 3, 32'h30, 1, 4, 32'h40);
      stepCycle("rst_fill2");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("arst_we_a", {31'd0, we_a}, 32'd0);
      checkOutput("arst_we_b", {31'd0, we_b}, 32'd0);
      checkOutput("arst_waddr_a", {27'd0, waddr_a}, 32'd0);
      checkOutput("arst_wdata_a", wdata_a, 32'd0);
      checkOutput("arst_waddr_b", {27'd0, waddr_b}, 32'd0);
      checkOutput("arst_wdata_b", wdata_b, 32'd0);
      checkOutput("arst_stall", stall_cnt, 32'd0);
      checkOutput("arst_ready", {31'd0, mdu_ready}, 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      expectIdle();
      stepCycle("post_rst1");
      expectIdle();
      stepCycle("post_rst2");
      checkOutput("post_rst_ready", {31'd0, mdu_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/wb_merge.md
WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: register address width.
REQ-002 Parameter DATA_WIDTH, default 32: register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 pa_valid / pa_rd / pa_data  input  1 / ADDR_WIDTH / DATA_WIDTH  pipe-A result; no backpressure, always accepted.
REQ-006 pb_valid / pb_rd / pb_data  input  1 / ADDR_WIDTH / DATA_WIDTH  pipe-B result, younger than pipe A in the same cycle; no backpressure.
REQ-007 mdu_valid / mdu_rd / mdu_data  input  1 / ADDR_WIDTH / DATA_WIDTH  multi-cycle unit result.
REQ-008 mdu_ready  output  1  buffer can accept an MDU result this cycle.
REQ-009 we_a / waddr_a / wdata_a  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port A.
REQ-010 we_b / waddr_b / wdata_b  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port B.
REQ-011 stall_cnt  output  32  cycles with an MDU entry buffered but not drained (see Configuration).

Function
REQ-012 An MDU transfer occurs when mdu_valid && mdu_ready; the result enters a 2-entry in-order FIFO.
REQ-013 mdu_ready SHALL be 1 when the FIFO count after this cycle's drain is below 2, i.e. entering a full FIFO is allowed only in a cycle where at least one entry drains.
REQ-014 All write-port outputs SHALL be registered: a result selected in cycle N appears on the ports in cycle N+1.
REQ-015 Pipe A drives port A and pipe B drives port B when valid; pipes always take priority over the FIFO.
REQ-016 The FIFO head drains to port A if pipe A is idle, else to port B if pipe B is idle; the second FIFO entry drains to port B in the same cycle only if both pipes are idle and the head took port A.
REQ-017 Writes with rd == 0 SHALL be suppressed (we deasserted) on every source; MDU rd == 0 transfers are accepted and discarded without occupying the FIFO.
REQ-018 pa_valid && pb_valid && pa_rd == pb_rd: only port B is written (we_a = 0 next cycle).
REQ-019 A valid pipe write to rd equal to a buffered FIFO entry's rd SHALL invalidate that entry (younger overwrite); invalidated entries are removed without writing.
REQ-020 An MDU result entering in the same cycle as a pipe write to the same rd SHALL be kept (the MDU result is younger).
REQ-021 Two FIFO entries draining in one cycle with equal rd: only the younger is written, on port B.
REQ-022 Port A and port B SHALL never be written to the same address in one cycle.
REQ-023 FIFO pointers are 1-bit and wrap modulo 2; count in 0..2.

Reset
REQ-024 rstn low SHALL immediately clear we_a, we_b, waddr_a, waddr_b, wdata_a, wdata_b, stall_cnt to 0 and empty the FIFO; mdu_ready = 1 while in reset.
REQ-025 Buffered MDU results are lost on reset mid-operation; first writes reappear one cycle after the first valid input following rstn release.

Configuration
REQ-026 Macro WB_MERGE_PERF_EN defined: stall_cnt increments (saturating at 32'hFFFF_FFFF) each cycle the FIFO is non-empty and no entry drains.
REQ-027 Macro WB_MERGE_PERF_EN undefined: stall_cnt is constant 0 and no counter logic is synthesized; all other behaviour identical.

Verification
REQ-028 pa_valid=1 rd=5 data=0x11, pb_valid=1 rd=6 data=0x22 in cycle N -> cycle N+1: we_a=1 waddr_a=5 wdata_a=0x11, we_b=1 waddr_b=6 wdata_b=0x22.
REQ-029 Both pipes rd=7 (0xAA on A, 0xBB on B) -> next cycle we_a=0, we_b=1 waddr_b=7 wdata_b=0xBB.
REQ-030 Both pipes busy 3 cycles while MDU offers rd=3 0x33 then rd=4 0x44 then rd=8 0x88 -> mdu_ready drops to 0 after two accepts; pipes go idle -> next cycle port A writes 3/0x33, port B writes 4/0x44; rd=8 accepted; stall_cnt=2 with WB_MERGE_PERF_EN, 0 without.
REQ-031 MDU rd=9 0x99 buffered, pipe A writes rd=9 0x01 while pipe B busy -> rd=9 written only with 0x01; entry 0x99 never appears.
REQ-032 pa_valid rd=0 data=0xFF and MDU rd=0 -> no write on either port, FIFO count stays 0.
REQ-033 rstn pulsed low with 2 FIFO entries and we_a=1 -> outputs 0 asynchronously, mdu_ready=1, no buffered write after release.
